fifo_param: RTL and testbench

- Parametrised successor to the team's 8x8 valid/ready FIFO: configurable data width and depth.
- Adds a fill-level output, almost-full/almost-empty flags, a synchronous flush, a registered read-data-valid strobe and an optional overwrite-oldest mode.
- Sits between a streaming producer and a consumer on a single clock domain.
- Keeps the existing handshake polarity: the FIFO drives the ready outputs, the peers drive the valid inputs.

---
 rtl/fifo_param_if.sv | 24 ++
 rtl/fifo_param.sv | 74 +++++++
 tb/tb_fifo_param.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/fifo_param_if.sv
// Producer/consumer handshake bundle for fifo_param.
// Pure wiring with no latency of its own.
// The FIFO drives both ready signals, and the peers drive both valid signals.
interface fifo_param_if #(
    parameter int DATA_W = 8
);
    logic              w_valid;
    logic              w_ready;
    logic [DATA_W-1:0] w_data;
    logic              r_valid;
    logic              r_ready;
    logic [DATA_W-1:0] r_data;
    logic              r_data_vld;

    // The slave side is the FIFO. The master side is the producer/consumer pair.
    modport master (
        output w_valid, w_data, r_valid,
        input  w_ready, r_ready, r_data, r_data_vld
    );
    modport slave (
        input  w_valid, w_data, r_valid,
        output w_ready, r_ready, r_data, r_data_vld
    );
endinterface

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with level/threshold flags, flush and optional overwrite-oldest mode.
// Latency: a write becomes poppable on the next cycle, and pop data is registered 1 cycle after the pop.
// Backpressure: w_ready drops when full (OVERWRITE=0) or stays high (OVERWRITE=1); r_ready is high while non-empty.
module fifo_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int AFULL_TH  = 6,
    parameter int AEMPTY_TH = 2,
    parameter bit OVERWRITE = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    fifo_param_if.slave                bus,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic                       dropped
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wp;
    logic [PW-1:0]     rp;
    logic              full;
    logic              w_fire;
    logic              r_fire;
    logic              drop;

    // The extra MSB on each pointer separates full from empty without a separate counter.
    assign level        = wp - rp;
    assign full         = (level == PW'(DEPTH));
    assign almost_full  = (level >= PW'(AFULL_TH));
    assign almost_empty = (level <= PW'(AEMPTY_TH));

    assign bus.r_ready  = (level != '0);
    assign bus.w_ready  = OVERWRITE ? 1'b1 : ~full;

    assign w_fire = bus.w_ready & bus.w_valid;
    assign r_fire = bus.r_ready & bus.r_valid;

    // When a write lands on a full FIFO with no pop, it drops the oldest word by advancing rp.
    assign drop   = OVERWRITE & full & w_fire & ~r_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem            <= '{default: '0};
            wp             <= '0;
            rp             <= '0;
            bus.r_data     <= '0;
            bus.r_data_vld <= 1'b0;
            dropped        <= 1'b0;
        end else if (flush) begin
            wp             <= '0;
            rp             <= '0;
            bus.r_data     <= '0;
            bus.r_data_vld <= 1'b0;
            dropped        <= 1'b0;
        end else begin
            if (w_fire) begin
                mem[wp[AW-1:0]] <= bus.w_data;
                wp              <= wp + PW'(1);
            end
            if (r_fire || drop) begin
                rp <= rp + PW'(1);
            end
            // The read uses the pre-edge slot contents, so a same-slot write this cycle is not seen.
            bus.r_data     <= r_fire ? mem[rp[AW-1:0]] : '0;
            bus.r_data_vld <= r_fire;
            dropped        <= drop;
        end
    end
endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param: a vector table for fill/drain plus sequences for wrap, full, overwrite, flush and async reset.
module tb_fifo_param;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush0, flush1;
    logic [3:0] level0, level1;
    logic       af0, ae0, dr0, af1, ae1, dr1;
    int         total = 0;
    int         bad   = 0;

    fifo_param_if #(.DATA_W(8)) if0 ();
    fifo_param_if #(.DATA_W(8)) if1 ();

    fifo_param #(.DATA_W(8), .DEPTH(8), .AFULL_TH(6), .AEMPTY_TH(2), .OVERWRITE(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .flush(flush0), .bus(if0),
        .level(level0), .almost_full(af0), .almost_empty(ae0), .dropped(dr0)
    );
    fifo_param #(.DATA_W(8), .DEPTH(8), .AFULL_TH(6), .AEMPTY_TH(2), .OVERWRITE(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .flush(flush1), .bus(if1),
        .level(level1), .almost_full(af1), .almost_empty(ae1), .dropped(dr1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       flush;
        logic       w_valid;
        logic [7:0] w_data;
        logic       r_valid;
        logic [3:0] level;
        logic       w_ready;
        logic       r_ready;
        logic       af;
        logic       ae;
        logic [7:0] r_data;
        logic       r_vld;
    } vec_t;

    vec_t tbl [17];

    function automatic vec_t mkv(input logic f, input logic wv, input logic [7:0] wd, input logic rv,
                                 input logic [3:0] lv, input logic wr, input logic rr,
                                 input logic af, input logic ae, input logic [7:0] rd, input logic vld);
        vec_t v;
        v.flush = f;  v.w_valid = wv; v.w_data = wd; v.r_valid = rv;
        v.level = lv; v.w_ready = wr; v.r_ready = rr; v.af = af; v.ae = ae;
        v.r_data = rd; v.r_vld = vld;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk0(input string t, input logic [3:0] lv, input logic wr, input logic rr,
                        input logic af, input logic ae, input logic [7:0] rd, input logic vld);
        chk({t, ".level"},        32'(level0),         32'(lv));
        chk({t, ".w_ready"},      32'(if0.w_ready),    32'(wr));
        chk({t, ".r_ready"},      32'(if0.r_ready),    32'(rr));
        chk({t, ".almost_full"},  32'(af0),            32'(af));
        chk({t, ".almost_empty"}, 32'(ae0),            32'(ae));
        chk({t, ".r_data"},       32'(if0.r_data),     32'(rd));
        chk({t, ".r_data_vld"},   32'(if0.r_data_vld), 32'(vld));
        chk({t, ".dropped"},      32'(dr0),            32'(0));
    endtask

    task automatic drv0(input logic f, input logic wv, input logic [7:0] wd, input logic rv);
        flush0 = f; if0.w_valid = wv; if0.w_data = wd; if0.r_valid = rv;
        @(posedge clk);
        #1;
    endtask

    task automatic drv1(input logic wv, input logic [7:0] wd, input logic rv);
        flush1 = 1'b0; if1.w_valid = wv; if1.w_data = wd; if1.r_valid = rv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] lv;
        logic [7:0] d;

        rst_n = 1'b0;
        flush0 = 1'b0; if0.w_valid = 1'b0; if0.w_data = '0; if0.r_valid = 1'b0;
        flush1 = 1'b0; if1.w_valid = 1'b0; if1.w_data = '0; if1.r_valid = 1'b0;
        #3;
        chk0("reset0", 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        chk("reset1.level",   32'(level1),      32'(0));
        chk("reset1.w_ready", 32'(if1.w_ready), 32'(1));
        chk("reset1.dropped", 32'(dr1),         32'(0));
        chk("reset1.ae",      32'(ae1),         32'(1));
        chk("reset1.af",      32'(af1),         32'(0));
        #4 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Overwrite mode: fill, overwrite once, then drain.
        for (int i = 0; i < 8; i++) drv1(1'b1, 8'h01 + 8'(i), 1'b0);
        chk("ow.fill.level",   32'(level1),      32'(8));
        chk("ow.fill.w_ready", 32'(if1.w_ready), 32'(1));
        chk("ow.fill.dropped", 32'(dr1),         32'(0));
        drv1(1'b1, 8'hA0, 1'b0);
        chk("ow.drop.dropped", 32'(dr1),    32'(1));
        chk("ow.drop.level",   32'(level1), 32'(8));
        drv1(1'b0, 8'h00, 1'b0);
        chk("ow.pulse_end", 32'(dr1), 32'(0));
        for (int i = 0; i < 8; i++) begin
            drv1(1'b0, 8'h00, 1'b1);
            d = (i < 7) ? 8'h02 + 8'(i) : 8'hA0;
            chk($sformatf("ow.pop%0d.r_data", i), 32'(if1.r_data),     32'(d));
            chk($sformatf("ow.pop%0d.vld", i),    32'(if1.r_data_vld), 32'(1));
        end
        chk("ow.empty.level", 32'(level1), 32'(0));

        // Fill 0x11..0x18, then drain, then pop while empty.
        for (int k = 1; k <= 8; k++)
            tbl[k-1] = mkv(1'b0, 1'b1, 8'h10 + 8'(k), 1'b0, 4'(k), k < 8, 1'b1, k >= 6, k <= 2, 8'h00, 1'b0);
        for (int j = 1; j <= 8; j++) begin
            lv = 4'(8 - j);
            tbl[7+j] = mkv(1'b0, 1'b0, 8'h00, 1'b1, lv, 1'b1, lv != 0, lv >= 6, lv <= 2, 8'h10 + 8'(j), 1'b1);
        end
        tbl[16] = mkv(1'b0, 1'b0, 8'h00, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 17; i++) begin
            drv0(tbl[i].flush, tbl[i].w_valid, tbl[i].w_data, tbl[i].r_valid);
            chk0($sformatf("tbl%0d", i), tbl[i].level, tbl[i].w_ready, tbl[i].r_ready,
                 tbl[i].af, tbl[i].ae, tbl[i].r_data, tbl[i].r_vld);
        end

        // Streaming at level 1 across the pointer wrap.
        drv0(1'b0, 1'b1, 8'h40, 1'b0);
        chk0("stream.pre", 4'd1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 20; i++) begin
            drv0(1'b0, 1'b1, 8'h41 + 8'(i), 1'b1);
            chk0($sformatf("stream%0d", i), 4'd1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h40 + 8'(i), 1'b1);
        end
        drv0(1'b0, 1'b0, 8'h00, 1'b1);
        chk0("stream.last", 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h54, 1'b1);

        // Full without overwrite: the read fires and the write is held off.
        for (int i = 0; i < 8; i++) drv0(1'b0, 1'b1, 8'h60 + 8'(i), 1'b0);
        chk0("full", 4'd8, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        drv0(1'b0, 1'b1, 8'h55, 1'b1);
        chk0("full.rw", 4'd7, 1'b1, 1'b1, 1'b1, 1'b0, 8'h60, 1'b1);
        drv0(1'b0, 1'b1, 8'h55, 1'b0);
        chk0("full.w", 4'd8, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) begin
            drv0(1'b0, 1'b0, 8'h00, 1'b1);
            lv = 4'(7 - i);
            d  = (i < 7) ? 8'h61 + 8'(i) : 8'h55;
            chk0($sformatf("full.drain%0d", i), lv, 1'b1, lv != 0, lv >= 6, lv <= 2, d, 1'b1);
        end

        // A flush beats a simultaneous write and read.
        for (int i = 0; i < 5; i++) drv0(1'b0, 1'b1, 8'h70 + 8'(i), 1'b0);
        chk0("flush.pre", 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        drv0(1'b1, 1'b1, 8'h99, 1'b1);
        chk0("flush", 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        drv0(1'b0, 1'b0, 8'h00, 1'b0);
        chk0("flush.after", 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);

        // Asynchronous reset between clock edges.
        for (int i = 0; i < 3; i++) drv0(1'b0, 1'b1, 8'h80 + 8'(i), 1'b0);
        drv0(1'b0, 1'b0, 8'h00, 1'b1);
        chk0("arst.pre", 4'd2, 1'b1, 1'b1, 1'b0, 1'b1, 8'h80, 1'b1);
        if0.r_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk0("arst", 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk0("arst.after", 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
